sipo_receiver: RTL and testbench



---
 rtl/sipo_pkg.sv | 13 +
 rtl/tick_gen.sv | 29 ++
 rtl/sipo_receiver.sv | 121 ++++++++++++
 tb/tb_sipo_receiver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link: FSM state encoding and frame bit levels.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; tick is a one-clk enable every 2^TICK_W clk cycles.
module tick_gen #(
  parameter int TICK_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  // Wrapping increment.
  always_comb begin
    cnt_d = cnt_q + {{(TICK_W-1){1'b0}}, 1'b1};
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {TICK_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out receiver: start bit, WIDTH data bits MSB-first, stop bit,
// all sampled on the prescaler tick; accepted words are presented on data_out.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int TICK_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             hold,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic             tick;
  state_e           state_q,      state_d;
  logic [WIDTH-1:0] shreg_q,      shreg_d;
  logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0] data_out_q,   data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q,  frame_err_d;
  logic             busy_q,       busy_d;

  tick_gen #(.TICK_W(TICK_W)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Next-state logic; every transition and output update is gated by tick.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (serial_in == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shreg_d = {shreg_q[WIDTH-2:0], serial_in};
          // Counter saturates at WIDTH so no wrap path exists.
          if (bit_cnt_q < CNT_FULL) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
          if (bit_cnt_q >= CNT_LAST) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (serial_in == STOP_BIT) begin
            frame_err_d = 1'b0;
            if (!hold) begin
              data_out_d   = shreg_q;
              data_valid_d = 1'b1;
            end else begin
              data_out_d = data_out_q;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= {WIDTH{1'b0}};
      bit_cnt_q    <= {CNT_W{1'b0}};
      data_out_q   <= {WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed plus randomized bench for sipo_receiver, checked against a frame-level model.
module tb_sipo_receiver;

  localparam int WIDTH  = 16;
  localparam int TICK_W = 2;
  localparam int PERIOD = 1 << TICK_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             serial_in = 1'b1;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Frame-level expectations
  int          pres_m = 0;
  logic        tick_edge = 1'b0;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_err = 1'b0;
  int          exp_pulses = 0;
  int          vcount = 0;
  int          dbl = 0;
  logic        prev_dv = 1'b0;

  sipo_receiver #(.WIDTH(WIDTH), .TICK_W(TICK_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .hold       (hold),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count data_valid pulses and any back-to-back highs
  always @(negedge clk) begin
    if (data_valid === 1'b1) vcount++;
    if (prev_dv === 1'b1 && data_valid === 1'b1) dbl++;
    prev_dv = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the prescaler is modelled as a counter modulo 2^TICK_W
  task automatic step();
    @(posedge clk);
    tick_edge = (rst_n === 1'b1) && (pres_m == PERIOD - 1);
    if (rst_n !== 1'b1) pres_m = 0;
    else pres_m = (pres_m + 1) % PERIOD;
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    serial_in = b;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_edge && n < 2 * PERIOD);
    chk("tick_bound", {31'd0, tick_edge}, 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] w, input logic stop, input logic hld,
                            input logic skip_start);
    logic v;
    if (!skip_start) begin
      send_bit(1'b0);
      chk("busy_start", {31'd0, busy}, 32'd1);
    end
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    chk("busy_before_stop", {31'd0, busy}, 32'd1);
    hold = hld;
    send_bit(stop);
    v = stop && !hld;
    exp_err = !stop;
    if (v) begin
      exp_data = w;
      exp_pulses++;
    end
    chk("dv_at_stop", {31'd0, data_valid}, {31'd0, v});
    chk("data_out", {16'd0, data_out}, {16'd0, exp_data});
    chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    hold = 1'b0;
    serial_in = 1'b1;
    step();
    chk("dv_one_clk", {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    logic        s;
    logic        h;

    // Reset with serial_in toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serial_in = i[0];
      step();
    end
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // First tick lands on the 4th clk after release: start bit held low from release
    rst_n = 1'b1;
    serial_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_early_tick", {31'd0, busy}, 32'd0);
    end
    step();
    chk("first_tick_busy", {31'd0, busy}, 32'd1);
    send_frame(16'hA5C3, 1'b1, 1'b0, 1'b1);

    // Bad stop, then recovery
    send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
    send_frame(16'h00FF, 1'b1, 1'b0, 1'b0);

    // Hold discards a good frame
    send_frame(16'hFFFF, 1'b1, 1'b1, 1'b0);

    // Reset after 7 data bits
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    serial_in = 1'b1;
    step();
    rst_n = 1'b1;
    exp_data = 16'h0000;
    exp_err = 1'b0;
    chk("midrst_data_out", {16'd0, data_out}, 32'd0);
    chk("midrst_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_dv", {31'd0, data_valid}, 32'd0);
    send_frame(16'h8001, 1'b1, 1'b0, 1'b0);

    // Idle with 1-clk low glitches between ticks
    for (int t = 0; t < 10; t++) begin
      serial_in = 1'b0;
      step();
      serial_in = 1'b1;
      send_bit(1'b1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_dv", {31'd0, data_valid}, 32'd0);
    end

    // Back-to-back frames, no idle gap
    send_frame(16'h0001, 1'b1, 1'b0, 1'b0);
    send_frame(16'hFFFE, 1'b1, 1'b0, 1'b0);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      w = 16'($urandom);
      s = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 3) == 0);
      send_frame(w, s, h, 1'b0);
    end

    step();
    chk("pulse_count", vcount, exp_pulses);
    chk("no_double_dv", dbl, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
